// File: rtl/tqvp_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_uart_pkg
// Brief    : Shared types and constants for the TQVP UART receive path.
// Revision : 1.0 - initial release
// ============================================================================
package tqvp_uart_pkg;

    // Oversample ticks per serial bit.
    localparam int unsigned OVERSAMPLE = 16;

    // Oversample count at which the start bit is re-checked (mid start bit).
    localparam int unsigned START_MID  = 7;

    // Last oversample count inside one bit period.
    localparam logic [3:0]  OS_LAST    = 4'(OVERSAMPLE - 1);

    // Receiver state encoding.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        BRK_WAIT = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/tqvp_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_uart_fifo
// Brief    : Small synchronous FIFO with extra-MSB pointers and a
//            combinational head read. Storage is not reset, only pointers.
// Revision : 1.0 - initial release
// ============================================================================
module tqvp_uart_fifo
    import tqvp_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wptr;
    logic [c_aw:0]    r_rptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Empty when pointers match; full when only the wrap bit differs.
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                   (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);

    // A pop while empty is ignored; a push while full only succeeds when
    // the same cycle frees the head slot.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | pop);

    assign data = r_mem[r_rptr[c_aw-1:0]];

    // Pointer update; both pointers wrap naturally through the extra MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[c_aw-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/tqvp_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_uart_rx
// Brief    : 16x oversampling UART receiver (8N1) with programmable baud
//            tick, receive FIFO, sticky framing/overrun flags and an irq.
// Revision : 1.0 - initial release
// ============================================================================
module tqvp_uart_rx
    import tqvp_uart_pkg::*;
#(
    parameter int DIV_W      = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxd,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [7:0]       rd_data,
    output logic             rx_valid,
    output logic             rx_full,
    output logic             frame_err,
    output logic             overrun,
    output logic             irq
);

    localparam logic [3:0] c_start_mid = 4'(START_MID);

    // Tick generator
    logic [DIV_W-1:0] r_tick_cnt;
    logic [DIV_W-1:0] r_div_lat;
    logic             w_tick;

    // Receiver FSM
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [3:0]       r_os_cnt;
    logic [3:0]       w_os_cnt_nxt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_cnt_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_push_req;
    logic             w_push_nxt;
    logic             w_ferr_set;

    // Flags and FIFO status
    logic             r_frame_err;
    logic             r_overrun;
    logic             r_irq;
    logic             w_ovr_set;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_head;

    // The divisor is latched only at a wrap so a mid-period change can
    // never shorten or stretch the current period into a glitch tick.
    assign w_tick = (r_tick_cnt == r_div_lat);

    // Free-running oversample tick counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_div_lat  <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
            r_div_lat  <= baud_div;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_push_req <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_os_cnt   <= w_os_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_push_req <= w_push_nxt;
        end
    end

    // Next-state logic; everything advances only on an oversample tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_os_cnt_nxt  = r_os_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_push_nxt    = 1'b0;
        w_ferr_set    = 1'b0;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (!rxd) begin
                        w_state_nxt  = START;
                        w_os_cnt_nxt = '0;
                    end
                end
                START: begin
                    // Re-check the line half a bit in; a high line was noise.
                    if (r_os_cnt == c_start_mid) begin
                        w_os_cnt_nxt  = '0;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = rxd ? IDLE : DATA;
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + 4'd1;
                    end
                end
                DATA: begin
                    // Counting from mid start bit, every 16th tick is mid-bit.
                    if (r_os_cnt == OS_LAST) begin
                        w_os_cnt_nxt  = '0;
                        w_shift_nxt   = {rxd, r_shift[7:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) w_state_nxt = STOP;
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (r_os_cnt == OS_LAST) begin
                        w_os_cnt_nxt = '0;
                        if (rxd) begin
                            w_push_nxt  = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_ferr_set  = 1'b1;
                            w_state_nxt = BRK_WAIT;
                        end
                    end else begin
                        w_os_cnt_nxt = r_os_cnt + 4'd1;
                    end
                end
                BRK_WAIT: begin
                    // Hold off until the line has returned high (break ends).
                    if (rxd) w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // A same-cycle pop frees the slot, so only an unpaired push overflows.
    assign w_ovr_set = r_push_req & w_full & ~rd_en;

    // Sticky error flags; a set event takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_ferr_set)   r_frame_err <= 1'b1;
            else if (clr_err) r_frame_err <= 1'b0;
            if (w_ovr_set)    r_overrun   <= 1'b1;
            else if (clr_err) r_overrun   <= 1'b0;
        end
    end

    // Registered interrupt request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq <= 1'b0;
        else        r_irq <= ~w_empty | r_frame_err | r_overrun;
    end

    tqvp_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_push_req),
        .push_data (r_shift),
        .pop       (rd_en),
        .data      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign rd_data   = w_empty ? 8'h00 : w_head;
    assign rx_valid  = ~w_empty;
    assign rx_full   = w_full;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign irq       = r_irq;

endmodule
`default_nettype wire

// File: doc/tqvp_uart_rx.md
TQVP_UART_RX -- requirements
Module: tqvp_uart_rx

Interface
REQ-001 SHALL take parameter DIV_W, default 12, width of the baud divisor.
REQ-002 SHALL take parameter FIFO_DEPTH, default 4, receive FIFO entries, power of two.
REQ-003 SHALL have port clk  input  1  the single clock; all state SHALL be clocked on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rxd  input  1  serial receive line, already 2-stage synchronized; idle high.
REQ-006 SHALL have port baud_div  input  DIV_W  oversample tick period minus 1, in clocks.
REQ-007 SHALL have port rd_en  input  1  pop one byte from the FIFO head.
REQ-008 SHALL have port clr_err  input  1  clear both sticky error flags.
REQ-009 SHALL have port rd_data  output  8  FIFO head byte; 0x00 when empty.
REQ-010 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-011 SHALL have port rx_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-012 SHALL have port frame_err  output  1  sticky framing-error flag.
REQ-013 SHALL have port overrun  output  1  sticky overrun flag.
REQ-014 SHALL have port irq  output  1  registered OR of rx_valid, frame_err and overrun.

Function
REQ-015 Tick generator SHALL count 0..baud_div and pulse tick for one clock on reaching baud_div; period = baud_div+1 clocks; baud_div=0 gives a tick every clock.
REQ-016 A baud_div change SHALL take effect at the next counter wrap; no glitch tick SHALL occur.
REQ-017 FSM states SHALL be IDLE, START, DATA, STOP, BRK_WAIT.
REQ-018 IDLE: rxd=0 sampled on a tick SHALL enter START and zero the 4-bit oversample counter.
REQ-019 START: on the 8th tick (counter=7), rxd=1 SHALL return to IDLE as a glitch; rxd=0 SHALL enter DATA with counter zeroed.
REQ-020 DATA: rxd SHALL be sampled every 16th tick, at mid-bit, LSB first, 8 bits, then enter STOP.
REQ-021 STOP: on the 16th tick, rxd=1 SHALL push the byte and return to IDLE.
REQ-022 STOP: on the 16th tick, rxd=0 SHALL discard the byte, set frame_err and enter BRK_WAIT.
REQ-023 BRK_WAIT SHALL leave for IDLE only after rxd=1 is sampled on a tick.
REQ-024 A push SHALL occur the clock after the stop-sample tick; rx_valid SHALL rise on the following clock edge.
REQ-025 rd_data SHALL show the head combinationally from FIFO storage with no read latency; rd_en with rx_valid=1 SHALL advance the head on the next edge.
REQ-026 rd_en while empty SHALL be ignored, with no pointer movement.
REQ-027 A push while full, without a same-cycle pop, SHALL drop the new byte and set overrun; FIFO contents SHALL be unchanged.
REQ-028 A push and pop in the same cycle while full SHALL both succeed and SHALL NOT set overrun.
REQ-029 A push and pop in the same cycle while empty SHALL treat the pop as ignored and accept the push.
REQ-030 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap naturally; full and empty SHALL be decoded from pointer MSB and index equality.
REQ-031 clr_err SHALL clear both flags on the next edge; a same-cycle set event SHALL win over clr_err.

Reset
REQ-032 Asserting rst_n low SHALL immediately return the FSM to IDLE and zero the tick counter, oversample counter, shift register and FIFO pointers.
REQ-033 Reset SHALL immediately clear frame_err, overrun, irq, rx_valid, rx_full and rd_data to 0.
REQ-034 A frame in progress at reset SHALL be abandoned with no push.
REQ-035 After release, reception SHALL restart only on a new falling edge of rxd seen in IDLE.

Structure
REQ-036 Package tqvp_uart_pkg SHALL hold the FSM state enum, the OVERSAMPLE=16 constant and the START_MID=7 constant.
REQ-037 The FIFO SHALL be a sub-module named tqvp_uart_fifo (parameters WIDTH and DEPTH; ports push/pop/data/full/empty), reusable by a future transmitter.
REQ-038 FIFO storage SHALL NOT be reset; only its pointers SHALL be reset.

Verification
REQ-039 With baud_div=0 (16 clocks/bit), frame 0xA5 with a valid stop bit -> rx_valid=1 and rd_data=0xA5 within 155 clocks of the start edge; frame_err=0.
REQ-040 A 4-clock low pulse on idle rxd -> FSM returns to IDLE, no push, rx_valid stays 0.
REQ-041 Frame 0x3C with stop bit 0, then rxd held low for 40 clocks -> frame_err=1, no push; next valid frame 0x11 is received correctly.
REQ-042 Bytes 0x01..0x05 sent without rd_en -> rx_full=1, overrun=1; pops return 0x01..0x04, then rx_valid=0.
REQ-043 rst_n pulsed low mid-way through the DATA bits of 0xFF -> no push, all outputs 0; next frame 0x5A is received correctly.
REQ-044 FIFO full, with rd_en asserted in the exact push cycle -> overrun stays 0, and the popped byte is the oldest.
